// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-source handshake and CDB lane bundle for cdb_arbiter
// master drives results and snoops the bus; slave is the arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_SRC   = 4,
  parameter int NUM_LANES = 2,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32
);
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC-1:0]          src_ready;
  logic [NUM_SRC*TAG_W-1:0]    src_tag;
  logic [NUM_SRC*DATA_W-1:0]   src_value;
  logic [NUM_LANES-1:0]        cdb_valid;
  logic [NUM_LANES*TAG_W-1:0]  cdb_tag;
  logic [NUM_LANES*DATA_W-1:0] cdb_value;
  logic                        cdb_busy;
  modport master (
    output src_valid, src_tag, src_value,
    input  src_ready, cdb_valid, cdb_tag, cdb_value, cdb_busy
  );
  modport slave (
    input  src_valid, src_tag, src_value,
    output src_ready, cdb_valid, cdb_tag, cdb_value, cdb_busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result queues granted round-robin onto a registered multi-lane CDB.
// Define CDB_BYPASS_EN to let a pushing source with an empty queue go straight to a lane.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_LANES  = 2,
  parameter int TAG_W      = 3,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NUM_SRC);
`ifdef CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic [TAG_W-1:0]            r_tag  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0]           r_val  [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]               r_head [NUM_SRC];
  logic [PW-1:0]               r_tail [NUM_SRC];
  logic [CW-1:0]               r_cnt  [NUM_SRC];
  logic [SW-1:0]               r_rr;
  logic [NUM_LANES-1:0]        r_cdb_valid;
  logic [NUM_LANES*TAG_W-1:0]  r_cdb_tag;
  logic [NUM_LANES*DATA_W-1:0] r_cdb_value;
  logic [NUM_SRC-1:0]          w_full, w_empty, w_push, w_req, w_gnt, w_pop, w_enq;
  logic [NUM_LANES-1:0]        w_lv;
  logic [NUM_LANES*TAG_W-1:0]  w_lt;
  logic [NUM_LANES*DATA_W-1:0] w_ld;
  logic [SW-1:0]               w_last;
  logic [SW-1:0]               w_rr_nxt;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w_full[i]  = r_cnt[i] == CW'(FIFO_DEPTH);
    assign w_empty[i] = r_cnt[i] == '0;
    assign w_push[i]  = bus.src_valid[i] & ~w_full[i] & ~flush;
    assign w_req[i]   = ~w_empty[i] | (BYP & w_push[i]);
    assign w_pop[i]   = w_gnt[i] & ~w_empty[i];
    // a granted push into an empty queue is the bypass path and never lands in the queue
    assign w_enq[i]   = w_push[i] & ~(w_gnt[i] & w_empty[i]);
  end
  always_comb begin
    int g, s;
    w_gnt  = '0;
    w_lv   = '0;
    w_lt   = '0;
    w_ld   = '0;
    w_last = r_rr;
    g      = 0;
    s      = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = (int'(r_rr) + j) % NUM_SRC;
      if (w_req[s] && g < NUM_LANES) begin
        w_gnt[s] = 1'b1;
        w_lv[g]  = 1'b1;
        w_lt[g*TAG_W +: TAG_W]   = w_empty[s] ? bus.src_tag[s*TAG_W +: TAG_W] : r_tag[s][r_head[s]];
        w_ld[g*DATA_W +: DATA_W] = w_empty[s] ? bus.src_value[s*DATA_W +: DATA_W] : r_val[s][r_head[s]];
        w_last = SW'(s);
        g++;
      end
    end
  end
  assign w_rr_nxt = SW'((int'(w_last) + 1) % NUM_SRC);
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_SRC; i++)
      if (w_enq[i]) begin
        r_tag[i][r_tail[i]] <= bus.src_tag[i*TAG_W +: TAG_W];
        r_val[i][r_tail[i]] <= bus.src_value[i*DATA_W +: DATA_W];
      end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_head[i] <= '0;
        r_tail[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rr        <= '0;
      r_cdb_valid <= '0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_head[i] <= flush ? '0 : r_head[i] + PW'(w_pop[i]);
        r_tail[i] <= flush ? '0 : r_tail[i] + PW'(w_enq[i]);
        r_cnt[i]  <= flush ? '0 : r_cnt[i] + CW'(w_enq[i]) - CW'(w_pop[i]);
      end
      r_rr        <= flush ? '0 : |w_gnt ? w_rr_nxt : r_rr;
      r_cdb_valid <= flush ? '0 : w_lv;
      r_cdb_tag   <= flush ? '0 : w_lt;
      r_cdb_value <= flush ? '0 : w_ld;
    end
  assign bus.src_ready = ~w_full & ~{NUM_SRC{flush}};
  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_value = r_cdb_value;
  assign bus.cdb_busy  = ~&w_empty;
endmodule
